// File: rtl/morse_key_decoder_if.sv
// Key input and decoded-letter outputs of the Morse key decoder.
// The decoder uses the slave modport. The key source and the display stage use the master modport.
interface morse_key_decoder_if;
  logic       key_i;
  logic [4:0] letter_o;
  logic       letter_valid_o;
  logic       error_o;
  logic       busy_o;

  modport master (
    output key_i,
    input  letter_o, letter_valid_o, error_o, busy_o
  );

  modport slave (
    input  key_i,
    output letter_o, letter_valid_o, error_o, busy_o
  );
endinterface

// File: rtl/morse_key_decoder.sv
// Samples and debounces a raw Morse key, then classifies marks as dot or dash.
// Each group closed by a letter gap is decoded to a letter index 0..25.
module morse_key_decoder #(
  parameter int TICK_DIV      = 1000,
  parameter int DEB_TICKS     = 5,
  parameter int DOT_MAX_TICKS = 150,
  parameter int GAP_TICKS     = 300
) (
  input  logic                clk_i,
  input  logic                rst_i,
  morse_key_decoder_if.slave  bus
);

  localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DEB_W = $clog2(DEB_TICKS + 1);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_TICKS - 1);
  localparam logic [8:0]       DOT_MAX  = 9'(DOT_MAX_TICKS);
  localparam logic [8:0]       GAP_MAX  = 9'(GAP_TICKS);

  typedef enum logic [1:0] {S_IDLE, S_MARK, S_SPACE, S_EMIT} state_t;

  logic             r_sync1, r_sync2;
  logic [PRE_W-1:0] r_pre;
  logic             w_tick;
  logic             r_key_db;
  logic [DEB_W-1:0] r_deb_cnt;

  state_t     r_state, w_state_nxt;
  logic [8:0] r_mark_cnt, w_mark_cnt_nxt;
  logic [8:0] r_gap_cnt, w_gap_cnt_nxt;
  logic [3:0] r_pattern, w_pattern_nxt;
  logic [2:0] r_len, w_len_nxt;
  logic       r_ovf, w_ovf_nxt;
  logic [4:0] r_letter, w_letter_nxt;
  logic       r_valid, w_valid_nxt;
  logic       r_error, w_error_nxt;

  logic       w_dash;
  logic [8:0] w_gap_inc;
  logic [8:0] w_mark_inc;
  logic       w_dec_ok;
  logic [4:0] w_dec_idx;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= bus.key_i;
      r_sync2 <= r_sync1;
    end
  end

  assign w_tick = (r_pre == PRE_LAST);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)       r_pre <= '0;
    else if (w_tick) r_pre <= '0;
    else             r_pre <= r_pre + 1'b1;
  end

  // A change is accepted only after DEB_TICKS consecutive differing tick samples.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_key_db  <= 1'b0;
      r_deb_cnt <= '0;
    end else if (w_tick) begin
      if (r_sync2 != r_key_db) begin
        if (r_deb_cnt == DEB_LAST) begin
          r_key_db  <= r_sync2;
          r_deb_cnt <= '0;
        end else begin
          r_deb_cnt <= r_deb_cnt + 1'b1;
        end
      end else begin
        r_deb_cnt <= '0;
      end
    end
  end

  always_comb begin
    w_dec_ok  = 1'b1;
    w_dec_idx = '0;
    case ({r_len, r_pattern})
      {3'd1, 4'b0000}: w_dec_idx = 5'd4;
      {3'd1, 4'b0001}: w_dec_idx = 5'd19;
      {3'd2, 4'b0000}: w_dec_idx = 5'd8;
      {3'd2, 4'b0001}: w_dec_idx = 5'd0;
      {3'd2, 4'b0010}: w_dec_idx = 5'd13;
      {3'd2, 4'b0011}: w_dec_idx = 5'd12;
      {3'd3, 4'b0000}: w_dec_idx = 5'd18;
      {3'd3, 4'b0001}: w_dec_idx = 5'd20;
      {3'd3, 4'b0010}: w_dec_idx = 5'd17;
      {3'd3, 4'b0011}: w_dec_idx = 5'd22;
      {3'd3, 4'b0100}: w_dec_idx = 5'd3;
      {3'd3, 4'b0101}: w_dec_idx = 5'd10;
      {3'd3, 4'b0110}: w_dec_idx = 5'd6;
      {3'd3, 4'b0111}: w_dec_idx = 5'd14;
      {3'd4, 4'b0000}: w_dec_idx = 5'd7;
      {3'd4, 4'b0001}: w_dec_idx = 5'd21;
      {3'd4, 4'b0010}: w_dec_idx = 5'd5;
      {3'd4, 4'b0100}: w_dec_idx = 5'd11;
      {3'd4, 4'b0110}: w_dec_idx = 5'd15;
      {3'd4, 4'b0111}: w_dec_idx = 5'd9;
      {3'd4, 4'b1000}: w_dec_idx = 5'd1;
      {3'd4, 4'b1001}: w_dec_idx = 5'd23;
      {3'd4, 4'b1010}: w_dec_idx = 5'd2;
      {3'd4, 4'b1011}: w_dec_idx = 5'd24;
      {3'd4, 4'b1100}: w_dec_idx = 5'd25;
      {3'd4, 4'b1101}: w_dec_idx = 5'd16;
      default:         w_dec_ok  = 1'b0;
    endcase
  end

  assign w_dash     = (r_mark_cnt >= DOT_MAX);
  assign w_gap_inc  = (r_gap_cnt == '1) ? r_gap_cnt : r_gap_cnt + 1'b1;
  assign w_mark_inc = (r_mark_cnt == '1) ? r_mark_cnt : r_mark_cnt + 1'b1;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= S_IDLE;
      r_mark_cnt <= '0;
      r_gap_cnt  <= '0;
      r_pattern  <= '0;
      r_len      <= '0;
      r_ovf      <= 1'b0;
      r_letter   <= '0;
      r_valid    <= 1'b0;
      r_error    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_mark_cnt <= w_mark_cnt_nxt;
      r_gap_cnt  <= w_gap_cnt_nxt;
      r_pattern  <= w_pattern_nxt;
      r_len      <= w_len_nxt;
      r_ovf      <= w_ovf_nxt;
      r_letter   <= w_letter_nxt;
      r_valid    <= w_valid_nxt;
      r_error    <= w_error_nxt;
    end
  end

  // The decode result is registered on the closing tick, so the strobe is visible
  // during the EMIT cycle. EMIT itself only picks the following state.
  always_comb begin
    w_state_nxt    = r_state;
    w_mark_cnt_nxt = r_mark_cnt;
    w_gap_cnt_nxt  = r_gap_cnt;
    w_pattern_nxt  = r_pattern;
    w_len_nxt      = r_len;
    w_ovf_nxt      = r_ovf;
    w_letter_nxt   = r_letter;
    w_valid_nxt    = 1'b0;
    w_error_nxt    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_key_db) begin
          w_state_nxt    = S_MARK;
          w_mark_cnt_nxt = '0;
          w_pattern_nxt  = '0;
          w_len_nxt      = '0;
          w_ovf_nxt      = 1'b0;
        end
      end
      S_MARK: begin
        if (!r_key_db) begin
          if (r_len < 3'd4) begin
            w_pattern_nxt = {r_pattern[2:0], w_dash};
            w_len_nxt     = r_len + 3'd1;
          end else begin
            w_ovf_nxt = 1'b1;
          end
          w_gap_cnt_nxt = '0;
          w_state_nxt   = S_SPACE;
        end else if (w_tick) begin
          w_mark_cnt_nxt = w_mark_inc;
        end
      end
      S_SPACE: begin
        if (w_tick && (w_gap_inc >= GAP_MAX)) begin
          w_gap_cnt_nxt = w_gap_inc;
          w_state_nxt   = S_EMIT;
          if (r_ovf || !w_dec_ok) begin
            w_error_nxt = 1'b1;
          end else begin
            w_valid_nxt  = 1'b1;
            w_letter_nxt = w_dec_idx;
          end
        end else if (r_key_db) begin
          w_state_nxt    = S_MARK;
          w_mark_cnt_nxt = '0;
        end else if (w_tick) begin
          w_gap_cnt_nxt = w_gap_inc;
        end
      end
      S_EMIT: begin
        if (r_key_db) begin
          w_state_nxt    = S_MARK;
          w_mark_cnt_nxt = '0;
          w_pattern_nxt  = '0;
          w_len_nxt      = '0;
          w_ovf_nxt      = 1'b0;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign bus.letter_o       = r_letter;
  assign bus.letter_valid_o = r_valid;
  assign bus.error_o        = r_error;
  assign bus.busy_o         = (r_state != S_IDLE);

endmodule

// File: tb/tb_morse_key_decoder.sv
// Directed bench for morse_key_decoder with short timing parameters.
module tb_morse_key_decoder;

  localparam int TD = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  int         n_valid = 0;
  int         n_error = 0;
  int         n_both  = 0;
  logic [4:0] last_letter = '0;

  int base_v, base_e;
  int busy_seen;

  morse_key_decoder_if bus ();

  morse_key_decoder #(
    .TICK_DIV      (TD),
    .DEB_TICKS     (2),
    .DOT_MAX_TICKS (10),
    .GAP_TICKS     (20)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.letter_valid_o) begin
        n_valid++;
        last_letter = bus.letter_o;
      end
      if (bus.error_o) n_error++;
      if (bus.letter_valid_o && bus.error_o) n_both++;
    end
  end

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic press(input int ticks);
    @(negedge clk) bus.key_i = 1'b1;
    repeat (ticks * TD) @(negedge clk);
    bus.key_i = 1'b0;
  endtask

  task automatic space(input int ticks);
    repeat (ticks * TD) @(negedge clk);
  endtask

  task automatic mark_base();
    base_v = n_valid;
    base_e = n_error;
  endtask

  task automatic expect_group(input string tag, input int dv, input int de, input int letter);
    check({tag, "_valid_cnt"}, n_valid - base_v, dv);
    check({tag, "_error_cnt"}, n_error - base_e, de);
    check({tag, "_letter"}, int'(bus.letter_o), letter);
    check({tag, "_busy"}, int'(bus.busy_o), 0);
  endtask

  initial begin
    bus.key_i = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_letter", int'(bus.letter_o), 0);
    check("reset_valid", int'(bus.letter_valid_o), 0);
    check("reset_error", int'(bus.error_o), 0);
    check("reset_busy", int'(bus.busy_o), 0);

    // E
    mark_base();
    press(5);
    check("e_busy_during", int'(bus.busy_o), 1);
    space(30);
    expect_group("e", 1, 0, 4);
    check("e_pulse_letter", int'(last_letter), 4);

    // A
    mark_base();
    press(5); space(5); press(15); space(30);
    expect_group("a", 1, 0, 0);

    // five dots: overflow
    mark_base();
    for (int i = 0; i < 5; i++) begin
      press(5); space(5);
    end
    space(25);
    expect_group("ovf", 0, 1, 0);

    // ---- unmapped
    mark_base();
    for (int i = 0; i < 4; i++) begin
      press(15); space(5);
    end
    space(25);
    expect_group("unmapped", 0, 1, 0);

    // Q = --.-
    mark_base();
    press(15); space(5); press(15); space(5);
    press(5); space(5); press(15); space(30);
    expect_group("q", 1, 0, 16);

    // chatter while idle
    mark_base();
    busy_seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk) bus.key_i = 1'b1;
      repeat (3) @(negedge clk);
      bus.key_i = 1'b0;
      for (int j = 0; j < 9; j++) begin
        @(negedge clk);
        if (bus.busy_o) busy_seen++;
      end
    end
    space(30);
    check("chatter_busy_cycles", busy_seen, 0);
    expect_group("chatter", 0, 0, 16);

    // long saturating mark -> dash -> T
    mark_base();
    press(600); space(30);
    expect_group("sat_t", 1, 0, 19);

    // reset in SPACE of a partial group
    mark_base();
    press(5); space(8);
    check("rst_busy_before", int'(bus.busy_o), 1);
    @(negedge clk) rst = 1'b1;
    #1;
    check("rst_letter", int'(bus.letter_o), 0);
    check("rst_busy", int'(bus.busy_o), 0);
    check("rst_valid", int'(bus.letter_valid_o), 0);
    check("rst_error", int'(bus.error_o), 0);
    repeat (4) @(negedge clk);
    rst = 1'b0;
    space(30);
    expect_group("rst_drop", 0, 0, 0);
    mark_base();
    press(5); space(30);
    expect_group("rst_e", 1, 0, 4);

    check("valid_error_overlap", n_both, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
